// File: rtl/intdiv_seq_pkg.sv
// Shared encodings and state type for the sequential integer divider.
package intdiv_seq_pkg;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divstate_t;

endpackage

// File: rtl/intdiv_seq_divstep.sv
// One restoring division iteration: shift {rem, quot} left and trial-subtract.
module intdiv_seq_divstep #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quot_i,
   input  logic [XLEN-1:0] dvsr_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quot_o
);

   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            fits;

   always_comb begin
      shifted = {rem_i, quot_i[XLEN-1]};
      fits    = (shifted >= {1'b0, dvsr_i});
      // When the divisor fits the true difference is below 2^XLEN, so modular math is exact
      diff    = shifted[XLEN-1:0] - dvsr_i;
      if (fits) begin
         rem_o  = diff;
         quot_o = {quot_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o  = shifted[XLEN-1:0];
         quot_o = {quot_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/intdiv_seq.sv
// Sequential radix-2 divider for DIV/DIVU/REM/REMU and the RV64 W forms.
module intdiv_seq
   import intdiv_seq_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            IntDivE,
   input  logic [XLEN-1:0] ForwardedSrcAE,
   input  logic [XLEN-1:0] ForwardedSrcBE,
   input  logic [2:0]      Funct3E,
   input  logic            W64E,
   input  logic            StallE,
   input  logic            StallM,
   input  logic            FlushE,
   input  logic            FlushM,
   output logic            DivBusyE,
   output logic [XLEN-1:0] DivResultM
);

   localparam int CW = $clog2(XLEN);

   divstate_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
   logic            qsign_q, qsign_d, rsign_q, rsign_d;
   logic            rem_sel_q, rem_sel_d, w_q, w_d;
   logic [XLEN-1:0] div_result_q, div_result_d;

   logic            w_e, sgn_op, a_sgn, b_sgn, b_zero;
   logic [31:0]     a32, b32, q32, r32, sel32;
   logic [XLEN-1:0] a_abs, b_abs, quot_init, res;
   logic [XLEN-1:0] step_rem, step_quot, qfix, rfix;

   function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic s);
      return s ? (32'd0 - v) : v;
   endfunction

   function automatic logic [XLEN-1:0] negx_if(input logic [XLEN-1:0] v, input logic s);
      return s ? ({XLEN{1'b0}} - v) : v;
   endfunction

   intdiv_seq_divstep #(.XLEN(XLEN)) u_divstep (
      .rem_i  (rem_q),
      .quot_i (quot_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quot_o (step_quot)
   );

   // Operand preparation: magnitudes and signs of the low N bits
   always_comb begin
      w_e    = W64E & (XLEN == 64);
      sgn_op = (Funct3E == F3_DIV) | (Funct3E == F3_REM);
      a32    = ForwardedSrcAE[31:0];
      b32    = ForwardedSrcBE[31:0];
      if (w_e) begin
         a_sgn     = sgn_op & a32[31];
         b_sgn     = sgn_op & b32[31];
         a_abs     = XLEN'(neg32_if(a32, a_sgn));
         b_abs     = XLEN'(neg32_if(b32, b_sgn));
         // Left-align the 32-bit dividend so 32 shifts consume it completely
         quot_init = a_abs << (XLEN - 32);
         b_zero    = (b32 == 32'd0);
      end else begin
         a_sgn     = sgn_op & ForwardedSrcAE[XLEN-1];
         b_sgn     = sgn_op & ForwardedSrcBE[XLEN-1];
         a_abs     = negx_if(ForwardedSrcAE, a_sgn);
         b_abs     = negx_if(ForwardedSrcBE, b_sgn);
         quot_init = a_abs;
         b_zero    = (ForwardedSrcBE == '0);
      end
   end

   always_comb begin
      q32   = neg32_if(quot_q[31:0], qsign_q);
      r32   = neg32_if(rem_q[31:0], rsign_q);
      sel32 = rem_sel_q ? r32 : q32;
      qfix  = negx_if(quot_q, qsign_q);
      rfix  = negx_if(rem_q, rsign_q);
      if (w_q) res = XLEN'($signed(sel32));
      else     res = rem_sel_q ? rfix : qfix;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      dvsr_d    = dvsr_q;
      qsign_d   = qsign_q;
      rsign_d   = rsign_q;
      rem_sel_d = rem_sel_q;
      w_d       = w_q;
      DivBusyE  = 1'b0;
      unique case (state_q)
         DIV_IDLE: begin
            DivBusyE = IntDivE & ~FlushE;
            if (IntDivE & ~FlushE) begin
               cnt_d     = w_e ? CW'(31) : CW'(XLEN - 1);
               dvsr_d    = b_abs;
               rsign_d   = a_sgn;
               rem_sel_d = (Funct3E == F3_REM) | (Funct3E == F3_REMU);
               w_d       = w_e;
               if (b_zero) begin
                  // All-ones quotient is left unsigned; the remainder un-negates back to the dividend
                  quot_d  = '1;
                  rem_d   = a_abs;
                  qsign_d = 1'b0;
                  state_d = DIV_DONE;
               end else begin
                  quot_d  = quot_init;
                  rem_d   = '0;
                  qsign_d = a_sgn ^ b_sgn;
                  state_d = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            DivBusyE = 1'b1;
            if (FlushE) begin
               state_d = DIV_IDLE;
            end else begin
               rem_d  = step_rem;
               quot_d = step_quot;
               if (cnt_q == '0) state_d = DIV_DONE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         DIV_DONE: begin
            if (FlushE | ~StallE) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      div_result_d = div_result_q;
      if (FlushM)
         div_result_d = '0;
      else if (~StallM)
         div_result_d = ((state_q == DIV_DONE) & ~FlushE) ? res : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= DIV_IDLE;
         cnt_q        <= '0;
         div_result_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_result_q <= div_result_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      rem_sel_q <= rem_sel_d;
      w_q       <= w_d;
   end

   assign DivResultM = div_result_q;

endmodule

// File: tb/tb_intdiv_seq.sv
// Directed self-checking bench for intdiv_seq at XLEN=64.
module tb_intdiv_seq;

   logic        clk;
   logic        reset;
   logic        IntDivE;
   logic [63:0] SrcA, SrcB;
   logic [2:0]  Funct3E;
   logic        W64E, StallE, StallM, FlushE, FlushM;
   logic        DivBusyE;
   logic [63:0] DivResultM;

   int n_checks = 0;
   int n_fail   = 0;

   int          busy;
   logic [63:0] res;

   intdiv_seq #(.XLEN(64)) dut (
      .clk            (clk),
      .reset          (reset),
      .IntDivE        (IntDivE),
      .ForwardedSrcAE (SrcA),
      .ForwardedSrcBE (SrcB),
      .Funct3E        (Funct3E),
      .W64E           (W64E),
      .StallE         (StallE),
      .StallM         (StallM),
      .FlushE         (FlushE),
      .FlushM         (FlushM),
      .DivBusyE       (DivBusyE),
      .DivResultM     (DivResultM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic start_div(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                            input logic w);
      IntDivE = 1'b1;
      Funct3E = f3;
      SrcA    = a;
      SrcB    = b;
      W64E    = w;
      #1;
   endtask

   // Counts cycles with DivBusyE high; returns once the divider reaches DONE.
   task automatic wait_busy(output int n);
      int guard;
      n     = 0;
      guard = 0;
      while (DivBusyE && guard < 200) begin
         n++;
         guard++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_div(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic w, output int n, output logic [63:0] r);
      start_div(f3, a, b, w);
      wait_busy(n);
      IntDivE = 1'b0;
      @(posedge clk);
      #1;
      r = DivResultM;
   endtask

   initial begin
      reset   = 1'b1;
      IntDivE = 1'b0;
      SrcA    = '0;
      SrcB    = '0;
      Funct3E = 3'b000;
      W64E    = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushE  = 1'b0;
      FlushM  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_busy", 64'(DivBusyE), 64'd0);
      chk("reset_result", DivResultM, 64'd0);

      run_div(3'b101, 64'd100, 64'd7, 1'b0, busy, res);
      chk("divu_busy_cycles", 64'(busy), 64'd65);
      chk("divu_100_7", res, 64'd14);
      @(posedge clk);
      #1;
      chk("result_one_cycle", DivResultM, 64'd0);

      run_div(3'b111, 64'd100, 64'd7, 1'b0, busy, res);
      chk("remu_100_7", res, 64'd2);

      run_div(3'b100, -64'sd7, 64'd2, 1'b0, busy, res);
      chk("div_busy_cycles", 64'(busy), 64'd65);
      chk("div_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
      run_div(3'b110, -64'sd7, 64'd2, 1'b0, busy, res);
      chk("rem_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFF);
      run_div(3'b110, 64'd7, -64'sd2, 1'b0, busy, res);
      chk("rem_7_m2", res, 64'd1);

      run_div(3'b100, 64'd5, 64'd0, 1'b0, busy, res);
      chk("div0_busy_cycles", 64'(busy), 64'd1);
      chk("div_5_0", res, 64'hFFFF_FFFF_FFFF_FFFF);
      run_div(3'b111, 64'd5, 64'd0, 1'b0, busy, res);
      chk("remu0_busy_cycles", 64'(busy), 64'd1);
      chk("remu_5_0", res, 64'd5);

      run_div(3'b100, 64'h8000_0000_0000_0000, -64'sd1, 1'b0, busy, res);
      chk("div_ovf", res, 64'h8000_0000_0000_0000);
      run_div(3'b110, 64'h8000_0000_0000_0000, -64'sd1, 1'b0, busy, res);
      chk("rem_ovf", res, 64'd0);

      run_div(3'b101, 64'h1234_5678_FFFF_FFFF, 64'd1, 1'b1, busy, res);
      chk("divuw_busy_cycles", 64'(busy), 64'd33);
      chk("divuw_sext", res, 64'hFFFF_FFFF_FFFF_FFFF);

      // Held in DONE by StallE with IntDivE still high, then FlushM clears the result
      start_div(3'b101, 64'd100, 64'd7, 1'b0);
      wait_busy(busy);
      StallE = 1'b1;
      @(posedge clk);
      #1;
      chk("done_stalle_busy", 64'(DivBusyE), 64'd0);
      chk("done_stalle_result", DivResultM, 64'd14);
      FlushM = 1'b1;
      @(posedge clk);
      #1;
      FlushM = 1'b0;
      chk("flushm_clears", DivResultM, 64'd0);
      StallE  = 1'b0;
      IntDivE = 1'b0;
      @(posedge clk);
      #1;
      chk("release_stalle", DivResultM, 64'd14);
      @(posedge clk);
      #1;

      // FlushE abort on the 10th BUSY cycle
      start_div(3'b101, 64'd100, 64'd7, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      FlushE  = 1'b1;
      IntDivE = 1'b0;
      @(posedge clk);
      #1;
      FlushE = 1'b0;
      chk("flush_abort_busy", 64'(DivBusyE), 64'd0);
      chk("flush_abort_result", DivResultM, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("flush_abort_result_later", DivResultM, 64'd0);
      run_div(3'b101, 64'd9, 64'd3, 1'b0, busy, res);
      chk("divu_9_3_after_flush", res, 64'd3);

      StallM = 1'b1;
      @(posedge clk);
      #1;
      chk("stallm_hold", DivResultM, 64'd3);

      // Reset abort on the 10th BUSY cycle while StallM holds a stale result
      start_div(3'b101, 64'd100, 64'd7, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset   = 1'b1;
      IntDivE = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_abort_busy", 64'(DivBusyE), 64'd0);
      chk("reset_abort_result", DivResultM, 64'd0);
      StallM = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_abort_result_later", DivResultM, 64'd0);
      run_div(3'b101, 64'd9, 64'd3, 1'b0, busy, res);
      chk("divu_9_3_after_reset_busy", 64'(busy), 64'd65);
      chk("divu_9_3_after_reset", res, 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/intdiv_seq.md
# intdiv_seq

Sequential radix-2 integer divider for the M-extension DIV/DIVU/REM/REMU and their RV64 W variants. It sits directly downstream of the integer execution unit. It consumes the forwarded Execute-stage operands, funct3, the divide strobe and the W64 flag, and holds the Execute stage through the hazard unit while it iterates. It delivers a registered result in the Memory stage for the writeback path.

## Interface
- XLEN, 64, datapath width (32 or 64).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- IntDivE  in  1  divide/remainder instruction in Execute.
- ForwardedSrcAE  in  XLEN  dividend.
- ForwardedSrcBE  in  XLEN  divisor.
- Funct3E  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- W64E  in  1  RV64 W-type op; ignored when XLEN=32.
- StallE, StallM  in  1  hazard-unit stalls.
- FlushE, FlushM  in  1  hazard-unit flushes.
- DivBusyE  out  1  structural stall request to the hazard unit.
- DivResultM  out  XLEN  quotient or remainder, Memory stage.

## Operation
- N = 32 when W64E, else XLEN. Operands are the low N bits.
- Signed ops (Funct3E[0]=0) take absolute values at start. Record the quotient sign (sign A xor sign B) and the remainder sign (sign A).
- State machine IDLE/BUSY/DONE. Reset value: IDLE.
- IDLE:
  - DivBusyE = IntDivE & ~FlushE, combinational.
  - On that edge, capture the absolute operands, the signs, funct3 and W64, and load counter = N-1.
  - Divisor zero: go to DONE. Otherwise go to BUSY.
- BUSY:
  - DivBusyE=1.
  - One restoring step per cycle: shift {rem, quot} left 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
  - Counter decrements. At counter==0 go to DONE.
- DONE:
  - DivBusyE=0.
  - Apply sign fixup: negate the quotient if its sign bit is set, negate the remainder if its sign bit is set.
  - Select the remainder when funct3[1]=1. If W64, sign-extend bit 31 to XLEN.
  - Stay in DONE while StallE; go to IDLE when ~StallE. IntDivE still high in DONE never restarts the divider.
- Divide by zero: quotient = all ones (N bits, then extended); remainder = dividend.
- Signed overflow (most-negative / -1) needs no special case. Required results: quotient = dividend, remainder = 0.
- FlushE in BUSY or DONE: go to IDLE at the next edge and drop the result. DivBusyE is 0 in the cycle after the flush.
- reset mid-operation: IDLE, counter 0, DivResultM 0 at the next edge.
- DivResultM register:
  - Loads the DONE result when ~StallM.
  - Loads 0 when FlushM, and also when leaving a state other than DONE.
  - Holds its value when StallM.
  - Reset value 0.

## Timing
- Nonzero divisor: DivBusyE is high for N+1 consecutive cycles, one IDLE-start cycle plus N BUSY cycles. The instruction leaves Execute at the end of the DONE cycle, so Execute residency is N+2 cycles: 66 for RV64, 34 for W ops.
- Zero divisor: DivBusyE high for 1 cycle; Execute residency 2 cycles.
- DivResultM is valid in the cycle after DONE with ~StallM, for one Memory-stage occupancy.
- Back-to-back divides: the second one starts in the cycle after DONE, in IDLE.
- FlushE takes priority over a start. FlushE in the same cycle as the IDLE start means no capture and DivBusyE=0.

## Structure
- Shared package:
  - Funct3 encodings DIV/DIVU/REM/REMU.
  - typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divstate_t.
- Sub-module divstep: combinational single restoring iteration, {rem, quot, divisor} in, {rem', quot'} out. This isolates it for later radix-4 replacement.
- Counter width $clog2(XLEN).

## Test plan
- XLEN=64, DIVU 100/7: DivBusyE high exactly 65 cycles, then DivResultM=14. The same operands with REMU give DivResultM=2.
- DIV -7/2 gives 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7/2 gives 0xFFFF_FFFF_FFFF_FFFF (-1). REM 7/-2 gives 1.
- DIV 5/0 gives 0xFFFF_FFFF_FFFF_FFFF and REMU 5/0 gives 5. In both, DivBusyE is high for 1 cycle.
- DIV 0x8000_0000_0000_0000 / -1 gives 0x8000_0000_0000_0000. REM with the same operands gives 0.
- DIVUW 0x1234_5678_FFFF_FFFF / 1:
  - DivBusyE high 33 cycles.
  - DivResultM = 0xFFFF_FFFF_FFFF_FFFF (bit-31 sign extension).
- Abort cases:
  - FlushE on the 10th BUSY cycle gives IDLE and DivBusyE=0 next cycle, and DivResultM stays 0.
  - An immediately following DIVU 9/3 still gives 3.
  - Repeat the abort with reset instead of FlushE; the same results are required.
